// File: rtl/updown_mod_counter.sv
// Up/down counter with a programmable modulus.
// Supports wrap or saturate at the range ends, parallel load with clamping,
// and an enable prescaler. It provides a registered terminal-count pulse and
// a sticky overflow flag.
module updown_mod_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MOD_MAX  = 255,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAXV     = WIDTH'(MOD_MAX);
    localparam logic [15:0]      PRE_LAST = 16'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [15:0]      pre_q, pre_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             step;
    logic             boundary;

    // Next-state: clr > load > step, then the sticky flag (set beats ovf_clr)
    always_comb begin
        count_d  = count_q;
        pre_d    = pre_q;
        boundary = 1'b0;
        step     = en && (pre_q == PRE_LAST);

        if (clr) begin
            count_d = '0;
            pre_d   = '0;
        end else if (load) begin
            count_d = (load_val > MAXV) ? MAXV : load_val;
            pre_d   = '0;
        end else if (en) begin
            if (step) begin
                pre_d = '0;
                if (up_dn) begin
                    if (count_q == MAXV) begin
                        boundary = 1'b1;
                        count_d  = (SATURATE != 0) ? MAXV : '0;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        boundary = 1'b1;
                        count_d  = (SATURATE != 0) ? '0 : MAXV;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end else begin
                pre_d = pre_q + 16'd1;
            end
        end

        tc_d = boundary;
        if (boundary) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            pre_q   <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_out = count_q;
    assign tc        = tc_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter.
// Five instances with different parameter sets share one input stream.
// Each instance is compared every cycle against an arithmetic reference
// model; directed scenarios add literal expectations.
module tb_updown_mod_counter;

    localparam int NI = 5;
    localparam int W_A  [NI] = '{4, 4, 4, 8, 6};
    localparam int MX_A [NI] = '{9, 9, 9, 255, 37};
    localparam int SAT_A[NI] = '{0, 1, 0, 0, 1};
    localparam int PS_A [NI] = '{1, 1, 3, 1, 2};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [7:0] lv = 8'd0;
    logic       ovf_clr = 1'b0;

    logic [3:0]  c0, c1, c2;
    logic [7:0]  c3;
    logic [5:0]  c4;
    logic [NI-1:0] dtc, dovf;
    logic [31:0] dcnt [NI];

    assign dcnt[0] = {28'd0, c0};
    assign dcnt[1] = {28'd0, c1};
    assign dcnt[2] = {28'd0, c2};
    assign dcnt[3] = {24'd0, c3};
    assign dcnt[4] = {26'd0, c4};

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    int m_cnt[NI];
    int m_pre[NI];
    bit m_tc [NI];
    bit m_ovf[NI];

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MOD_MAX(9), .SATURATE(0), .PRESCALE(1)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
        .load_val(lv[3:0]), .ovf_clr(ovf_clr), .count_out(c0), .tc(dtc[0]), .ovf(dovf[0]));
    updown_mod_counter #(.WIDTH(4), .MOD_MAX(9), .SATURATE(1), .PRESCALE(1)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
        .load_val(lv[3:0]), .ovf_clr(ovf_clr), .count_out(c1), .tc(dtc[1]), .ovf(dovf[1]));
    updown_mod_counter #(.WIDTH(4), .MOD_MAX(9), .SATURATE(0), .PRESCALE(3)) u2 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
        .load_val(lv[3:0]), .ovf_clr(ovf_clr), .count_out(c2), .tc(dtc[2]), .ovf(dovf[2]));
    updown_mod_counter #(.WIDTH(8), .MOD_MAX(255), .SATURATE(0), .PRESCALE(1)) u3 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
        .load_val(lv), .ovf_clr(ovf_clr), .count_out(c3), .tc(dtc[3]), .ovf(dovf[3]));
    updown_mod_counter #(.WIDTH(6), .MOD_MAX(37), .SATURATE(1), .PRESCALE(2)) u4 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
        .load_val(lv[5:0]), .ovf_clr(ovf_clr), .count_out(c4), .tc(dtc[4]), .ovf(dovf[4]));

    // Reference model: count stays in 0..MX; steps move it by one with modular wrap or clamping
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            int v;
            bit bnd;
            bnd = 1'b0;
            if (rst) begin
                m_cnt[i] = 0; m_pre[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
            end else begin
                if (clr) begin
                    m_cnt[i] = 0; m_pre[i] = 0;
                end else if (load) begin
                    v = int'(lv) % (1 << W_A[i]);
                    m_cnt[i] = (v > MX_A[i]) ? MX_A[i] : v;
                    m_pre[i] = 0;
                end else if (en) begin
                    m_pre[i] = m_pre[i] + 1;
                    if (m_pre[i] == PS_A[i]) begin
                        m_pre[i] = 0;
                        if (up_dn) begin
                            bnd = (m_cnt[i] == MX_A[i]);
                            if (SAT_A[i] != 0) m_cnt[i] = bnd ? MX_A[i] : m_cnt[i] + 1;
                            else m_cnt[i] = (m_cnt[i] + 1) % (MX_A[i] + 1);
                        end else begin
                            bnd = (m_cnt[i] == 0);
                            if (SAT_A[i] != 0) m_cnt[i] = bnd ? 0 : m_cnt[i] - 1;
                            else m_cnt[i] = (m_cnt[i] + MX_A[i]) % (MX_A[i] + 1);
                        end
                    end
                end
                m_tc[i] = bnd;
                if (bnd) m_ovf[i] = 1'b1;
                else if (ovf_clr) m_ovf[i] = 1'b0;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of all instances against the model
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NI; i++) begin
                check($sformatf("cnt[%0d]", i), dcnt[i], 32'(m_cnt[i]));
                check($sformatf("tc[%0d]", i), {31'd0, dtc[i]}, {31'd0, m_tc[i]});
                check($sformatf("ovf[%0d]", i), {31'd0, dovf[i]}, {31'd0, m_ovf[i]});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int exp2[6];
        int ntc;
        int mx;
        exp2 = '{0, 0, 1, 1, 1, 2};

        // Reset then count up with wrap
        cyc();
        rst = 1'b0;
        chk_on = 1'b1;
        check("rst_cnt", dcnt[0], 0);
        check("rst_ovf", {31'd0, dovf[0]}, 0);
        en = 1'b1; up_dn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            check("upwrap_cnt", dcnt[0], 32'(k % 10));
            check("upwrap_tc", {31'd0, dtc[0]}, (k == 10) ? 1 : 0);
            check("upwrap_ovf", {31'd0, dovf[0]}, (k >= 10) ? 1 : 0);
        end

        // Down wrap versus down saturate
        en = 1'b0; load = 1'b1; lv = 8'd1;
        cyc();
        load = 1'b0;
        check("ld1_cnt0", dcnt[0], 1);
        check("ld1_cnt1", dcnt[1], 1);
        en = 1'b1; up_dn = 1'b0;
        cyc();
        check("dn1_cnt0", dcnt[0], 0);
        check("dn1_tc1", {31'd0, dtc[1]}, 0);
        cyc();
        check("dn2_cnt0", dcnt[0], 9);
        check("dn2_tc0", {31'd0, dtc[0]}, 1);
        check("dn2_cnt1", dcnt[1], 0);
        check("dn2_tc1", {31'd0, dtc[1]}, 1);
        cyc();
        check("dn3_cnt1", dcnt[1], 0);
        check("dn3_tc1", {31'd0, dtc[1]}, 1);
        check("dn3_ovf1", {31'd0, dovf[1]}, 1);
        en = 1'b0;

        // Load clamp and priority
        load = 1'b1; lv = 8'd14;
        cyc();
        check("clamp", dcnt[0], 9);
        clr = 1'b1;
        cyc();
        check("clr_over_load", dcnt[0], 0);
        clr = 1'b0; rst = 1'b1; lv = 8'd5;
        cyc();
        check("rst_over_load", dcnt[0], 0);
        rst = 1'b0; en = 1'b1; up_dn = 1'b1; lv = 8'd3;
        cyc();
        check("load_over_step", dcnt[0], 3);
        load = 1'b0; en = 1'b0;

        // Prescaler of 3
        clr = 1'b1;
        cyc();
        clr = 1'b0; en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("pre_cnt", dcnt[2], 32'(exp2[k]));
        end
        cyc();
        en = 1'b0;
        cyc(); cyc();
        en = 1'b1;
        cyc();
        check("pre_gap_hold", dcnt[2], 2);
        cyc();
        check("pre_gap_step", dcnt[2], 3);
        cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        check("pre_clr", dcnt[2], 0);
        cyc(); cyc();
        check("pre_clr_hold", dcnt[2], 0);
        cyc();
        check("pre_clr_step", dcnt[2], 1);
        en = 1'b0;

        // Sticky overflow flag
        rst = 1'b1;
        cyc();
        rst = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int k = 0; k < 10; k++) cyc();
        check("sticky_set", {31'd0, dovf[0]}, 1);
        en = 1'b0; ovf_clr = 1'b1;
        cyc();
        check("sticky_clr", {31'd0, dovf[0]}, 0);
        ovf_clr = 1'b0; load = 1'b1; lv = 8'd9;
        cyc();
        load = 1'b0; en = 1'b1; ovf_clr = 1'b1;
        cyc();
        check("set_wins_cnt", dcnt[0], 0);
        check("set_wins_ovf", {31'd0, dovf[0]}, 1);
        en = 1'b0; ovf_clr = 1'b0; clr = 1'b1;
        cyc();
        clr = 1'b0;
        check("clr_keeps_ovf", {31'd0, dovf[0]}, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_clears_ovf", {31'd0, dovf[0]}, 0);

        // Full 8-bit range
        en = 1'b1; up_dn = 1'b1; ntc = 0; mx = 0;
        for (int k = 0; k < 256; k++) begin
            cyc();
            if (dtc[3] === 1'b1) ntc++;
            if (int'(dcnt[3]) > mx) mx = int'(dcnt[3]);
        end
        check("full_tc_count", 32'(ntc), 1);
        check("full_end", dcnt[3], 0);
        check("full_max", 32'(mx), 255);
        for (int k = 0; k < 8; k++) begin
            up_dn = k[0];
            cyc();
            check("alt_cnt", dcnt[3], k[0] ? 0 : 255);
            check("alt_tc", {31'd0, dtc[3]}, 1);
        end

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            rst     = ($urandom_range(0, 199) == 0);
            clr     = ($urandom_range(0, 49) == 0);
            load    = ($urandom_range(0, 24) == 0);
            ovf_clr = ($urandom_range(0, 19) == 0);
            en      = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
            lv      = 8'($urandom);
            cyc();
        end

        rst = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; ovf_clr = 1'b0;
        cyc();
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised synchronous up/down counter with programmable modulus, wrap or saturate mode, parallel load, enable prescaler, terminal-count pulse and sticky overflow flag. It is the general-purpose successor to the fixed 4-bit free-running counter. It serves as the event/timebase counter for datapath and control blocks that need arbitrary widths, ranges and directions.

## Interface
Parameters:
- WIDTH, 8: counter width in bits; legal range 2..32.
- MOD_MAX, 255: highest count value. Range is 0..MOD_MAX. Must satisfy 1 <= MOD_MAX <= 2^WIDTH-1.
- SATURATE, 0: selects boundary behaviour. 0 = wrap at a boundary; 1 = hold at the boundary.
- PRESCALE, 1: number of enabled cycles per count step; legal range 1..65535.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- clr  in  1  synchronous clear of count and prescaler.
- en  in  1  count enable; advances the prescaler.
- up_dn  in  1  direction: 1 = up, 0 = down. Sampled on step cycles.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value to load.
- ovf_clr  in  1  clears the sticky overflow flag.
- count_out  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered, one cycle wide.
- ovf  out  1  sticky boundary flag, registered.

## Operation
- Priority per edge: rst > clr > load > step. Lower-priority actions are ignored in that cycle.
- rst: count_out=0, tc=0, ovf=0, prescaler=0.
- clr: count_out=0, prescaler=0, tc=0. ovf is unchanged.
- load: count_out=min(load_val, MOD_MAX), prescaler=0, tc=0. A load never sets ovf.
- Prescaler: internal counter pre over 0..PRESCALE-1.
  - Increments only when en=1 and there is no rst, clr or load.
  - step = en && (pre==PRESCALE-1). On a step, pre returns to 0.
  - With PRESCALE=1, step = en.
  - en=0 freezes pre; it is not reset.
- Step, up (up_dn=1):
  - count<MOD_MAX: count+1.
  - count==MOD_MAX, SATURATE=0: count becomes 0 and the step is a boundary event.
  - count==MOD_MAX, SATURATE=1: count holds and the step is a boundary event.
- Step, down (up_dn=0):
  - count>0: count-1.
  - count==0, SATURATE=0: count becomes MOD_MAX and the step is a boundary event.
  - count==0, SATURATE=1: count holds and the step is a boundary event.
- Boundary event: tc=1 for exactly the cycle after the edge that performed the step. ovf is set.
- tc is 0 in every other cycle. Consecutive boundary events in saturate mode produce tc high on consecutive cycles.
- ovf:
  - Cleared by ovf_clr.
  - If a boundary event and ovf_clr occur on the same edge, set wins and ovf=1.
  - rst clears ovf. clr does not.
- Arithmetic: all compares are unsigned against MOD_MAX, never against 2^WIDTH-1. count_out never exceeds MOD_MAX.
- Reset or clr mid-prescale discards partial progress. The next step needs a full PRESCALE enabled cycles.

## Timing
- Latency from a step-qualifying edge to the new count_out value: 1 clock, registered output.
- tc and ovf change on the same edge as the associated count_out update.
- load, clr and rst take effect on the sampling edge. Their result is visible in the following cycle.
- up_dn change takes effect on the next step. No pipeline hazard, no dead cycle.
- Outputs have no combinational path from any input.
- Throughput: one step per cycle when PRESCALE=1 and en is held high.

## Test plan
- Reset/up-wrap, WIDTH=4, MOD_MAX=9, SATURATE=0, PRESCALE=1: assert rst, then hold en=1, up_dn=1 for 12 cycles.
  - count_out: 0,1,...,9,0,1,2.
  - tc high only in the cycle count_out shows 0 after 9.
  - ovf=1 from then on.
- Down-wrap/saturate, MOD_MAX=9:
  - SATURATE=0: load 1, step down twice. Expect count_out 0, then 9 with tc.
  - SATURATE=1: load 1, step down 3 times. Expect 0, 0, 0, with tc high on the 2nd and 3rd update and ovf=1.
- Load clamp/priority, MOD_MAX=9: load_val=14 gives count_out=9.
  - load and clr asserted together give 0.
  - rst with load_val=5 gives 0.
  - load with en=1 ignores the step.
- Prescaler, PRESCALE=3, en=1 continuously: count increments every 3rd cycle (0,0,0,1,1,1,2).
  - Drop en for 2 cycles mid-period: the period is extended by exactly 2 cycles.
  - Assert clr mid-period: the next step occurs 3 enabled cycles later.
- Sticky flag: after a wrap sets ovf, pulse ovf_clr. Expect ovf=0 next cycle.
  - Coincide ovf_clr with the next wrap edge: expect ovf=1.
  - clr leaves ovf=1. rst clears it.
- Full-range, WIDTH=8, MOD_MAX=255, up 256 steps from 0:
  - count returns to 0 with a single tc.
  - count_out never exceeds 255.
  - Repeat with up_dn toggled every step: count alternates 0,255,0,... with tc on every step.
